lfsr_seq_checker: RTL and testbench

//  Receive-side checker for the 8-bit audio noise LFSR serial output (LFSR[7], one bit per audio_clk_en).

---
 rtl/lfsr_seq_checker.sv | 147 ++++++++++++++
 tb/tb_lfsr_seq_checker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 8-bit audio noise LFSR serial stream: self-syncs, predicts, reports lock/mismatch/stuck.
// Optional mismatch statistics counter enabled by defining LFSR_CHECK_STATS_EN.
module lfsr_seq_checker #(
  parameter logic [7:0]  TAP_MASK   = 8'hB8,
  parameter int unsigned LOCK_RUN   = 16,
  parameter int unsigned LOSS_LIMIT = 4,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             I_RSTn,
  input  logic             audio_clk_en,
  input  logic             bit_in,
  input  logic             clear,
  output logic             locked,
  output logic             mismatch,
  output logic             stuck,
  output logic             predicted,
  output logic [7:0]       hist,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned HIST_W = 8;
  localparam int unsigned FILL_W = 4;
  localparam int unsigned RUN_W  = 8;
  localparam int unsigned MISS_W = 4;

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_VERIFY  = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [HIST_W-1:0]   hist_q, hist_d;
  logic                mismatch_d, stuck_d, pred_c;

  assign pred_c = ^(hist_q & TAP_MASK);

  // State register and registered outputs
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q   <= ST_ACQUIRE;
      fill_q    <= '0;
      run_q     <= '0;
      miss_q    <= '0;
      hist_q    <= '0;
      locked    <= 1'b0;
      mismatch  <= 1'b0;
      stuck     <= 1'b0;
      predicted <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      run_q     <= run_d;
      miss_q    <= miss_d;
      hist_q    <= hist_d;
      locked    <= (state_d == ST_LOCKED);
      mismatch  <= mismatch_d;
      stuck     <= stuck_d;
      predicted <= ^(hist_d & TAP_MASK);
    end
  end

  assign hist = hist_q;

  // Next-state: shift, compare against pre-shift prediction, advance lock FSM
  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    run_d      = run_q;
    miss_d     = miss_q;
    hist_d     = hist_q;
    mismatch_d = 1'b0;
    stuck_d    = 1'b0;
    if (clear) begin
      state_d = ST_ACQUIRE;
      fill_d  = '0;
      run_d   = '0;
      miss_d  = '0;
      hist_d  = '0;
    end else if (audio_clk_en) begin
      hist_d     = {hist_q[HIST_W-2:0], bit_in};
      stuck_d    = (hist_d == '0);
      mismatch_d = (state_q != ST_ACQUIRE) && (bit_in != pred_c);
      case (state_q)
        ST_ACQUIRE: begin
          fill_d = fill_q + FILL_W'(1);
          if (fill_d == FILL_W'(HIST_W)) begin
            state_d = ST_VERIFY;
            run_d   = '0;
          end
        end
        ST_VERIFY: begin
          if (mismatch_d) begin
            run_d = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
            if (run_d == RUN_W'(LOCK_RUN)) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (mismatch_d) begin
            miss_d = miss_q + MISS_W'(1);
            if (miss_d == MISS_W'(LOSS_LIMIT)) begin
              state_d = ST_VERIFY;
              run_d   = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = ST_ACQUIRE;
      endcase
      // An all-zero history cannot come from a running generator: restart acquisition
      if (stuck_d && (state_q != ST_ACQUIRE)) begin
        state_d = ST_ACQUIRE;
        fill_d  = '0;
      end
    end
  end

`ifdef LFSR_CHECK_STATS_EN
  logic [ERR_W-1:0] err_q;

  // Saturating mismatch counter
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      err_q <= '0;
    end else if (clear) begin
      err_q <= '0;
    end else if (mismatch_d && !(&err_q)) begin
      err_q <= err_q + ERR_W'(1);
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed scenarios plus randomized stream, checked against a bit-queue reference model.
`timescale 1ns/1ps
module tb_lfsr_seq_checker;

  localparam int LOCK_RUN   = 16;
  localparam int LOSS_LIMIT = 4;
  localparam int M_ACQ  = 0;
  localparam int M_VER  = 1;
  localparam int M_LOCK = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, bin, clr;
  logic        locked, mismatch, stuck, predicted;
  logic [7:0]  hist;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  lfsr_seq_checker dut (
    .clk(clk), .I_RSTn(rst_n), .audio_clk_en(en), .bit_in(bin), .clear(clr),
    .locked(locked), .mismatch(mismatch), .stuck(stuck), .predicted(predicted),
    .hist(hist), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference model: last 8 received bits (oldest first), mode, run lengths
  bit          mq[$];
  int          mode, acq_n, good_n, bad_n;
  logic [15:0] err_m;
  logic        mm_e, st_e;
  int          mm_total;

  // Generator model: emits 8 ones, then o[n]=o[n-8]^o[n-6]^o[n-5]^o[n-4]
  bit          gq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    repeat (8) mq.push_back(1'b0);
    mode = M_ACQ; acq_n = 0; good_n = 0; bad_n = 0;
    err_m = '0; mm_e = 1'b0; st_e = 1'b0;
  endtask

  function automatic logic [7:0] model_hist();
    logic [7:0] h;
    for (int i = 0; i < 8; i++) h[i] = mq[7-i];
    return h;
  endfunction

  function automatic logic model_pred();
    return mq[0] ^ mq[2] ^ mq[3] ^ mq[4];
  endfunction

  task automatic model_step(input logic e, input logic b, input logic c);
    logic p;
    int   prev;
    mm_e = 1'b0; st_e = 1'b0;
    if (c) begin
      model_reset();
    end else if (e) begin
      p    = model_pred();
      prev = mode;
      mm_e = (mode != M_ACQ) && (b != p);
      mq.push_back(b); void'(mq.pop_front());
      st_e = (model_hist() == 8'h00);
      if (mode == M_ACQ) begin
        acq_n++;
        if (acq_n == 8) begin mode = M_VER; good_n = 0; end
      end else if (mode == M_VER) begin
        if (mm_e) good_n = 0;
        else begin
          good_n++;
          if (good_n == LOCK_RUN) begin mode = M_LOCK; bad_n = 0; end
        end
      end else begin
        if (mm_e) begin
          bad_n++;
          if (bad_n == LOSS_LIMIT) begin mode = M_VER; good_n = 0; end
        end else bad_n = 0;
      end
      if (st_e && prev != M_ACQ) begin mode = M_ACQ; acq_n = 0; end
`ifdef LFSR_CHECK_STATS_EN
      if (mm_e && err_m != 16'hFFFF) err_m++;
`endif
      if (mm_e) mm_total++;
    end
  endtask

  task automatic step(input logic e, input logic b, input logic c);
    en = e; bin = b; clr = c;
    @(posedge clk);
    #1;
    model_step(e, b, c);
    chk("locked",    32'(locked),    32'(mode == M_LOCK));
    chk("mismatch",  32'(mismatch),  32'(mm_e));
    chk("stuck",     32'(stuck),     32'(st_e));
    chk("predicted", 32'(predicted), 32'(model_pred()));
    chk("hist",      32'(hist),      32'(model_hist()));
    chk("err_count", 32'(err_count), 32'(err_m));
  endtask

  task automatic gen_reset();
    gq.delete();
  endtask

  task automatic gen_bit(output logic b);
    int n;
    n = gq.size();
    if (n < 8) b = 1'b1;
    else b = gq[n-8] ^ gq[n-6] ^ gq[n-5] ^ gq[n-4];
    gq.push_back(b);
    if (gq.size() > 8) void'(gq.pop_front());
  endtask

  initial begin
    logic b;
    int   lock_at, mm_before;
    bit   got;

    rst_n = 1'b0; en = 1'b0; bin = 1'b0; clr = 1'b0; mm_total = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_hist",   32'(hist),   32'd0);
    chk("rst_err",    32'(err_count), 32'd0);
    chk("rst_pred",   32'(predicted), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: eight ones fill history, then a 0 is the correct prediction
    repeat (8) step(1'b1, 1'b1, 1'b0);
    chk("t1_hist", 32'(hist), 32'hFF);
    chk("t1_pred", 32'(predicted), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("t1_nomm", 32'(mismatch), 32'd0);

    // 2: clean generator stream; lock after 24th bit
    step(1'b0, 1'b0, 1'b1);
    gen_reset();
    lock_at = 0;
    for (int i = 1; i <= 40; i++) begin
      gen_bit(b);
      step(1'b1, b, 1'b0);
      if (locked && lock_at == 0) lock_at = i;
    end
    chk("t2_lock_at", 32'(lock_at), 32'd24);
    chk("t2_no_mm", 32'(mm_total), 32'd0);
    chk("t2_err", 32'(err_count), 32'd0);

    // 3: three isolated inversions keep lock
    for (int k = 0; k < 3; k++) begin
      gen_bit(b);
      step(1'b1, ~b, 1'b0);
      chk("t3_mm_pulse", 32'(mismatch), 32'd1);
      repeat (12) begin gen_bit(b); step(1'b1, b, 1'b0); end
      chk("t3_locked", 32'(locked), 32'd1);
    end

    // 4: four consecutive inversions drop lock, then relock
    for (int k = 0; k < 4; k++) begin gen_bit(b); step(1'b1, ~b, 1'b0); end
    chk("t4_unlock", 32'(locked), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      gen_bit(b); step(1'b1, b, 1'b0);
      got = locked;
    end
    chk("t4_relock", 32'(got), 32'd1);

    // 5: eight zeros while locked -> stuck on the 8th
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 1'b0);
    chk("t5_stuck", 32'(stuck), 32'd1);
    chk("t5_unlock", 32'(locked), 32'd0);

    // 6: relock, then clear with simultaneous strobe
    step(1'b0, 1'b0, 1'b1);
    gen_reset();
    for (int i = 0; i < 30; i++) begin gen_bit(b); step(1'b1, b, 1'b0); end
    chk("t6_locked", 32'(locked), 32'd1);
    step(1'b1, 1'b1, 1'b1);
    chk("t6_hist", 32'(hist), 32'd0);
    chk("t6_unlock", 32'(locked), 32'd0);

    // Async reset mid-lock
    gen_reset();
    for (int i = 0; i < 30; i++) begin gen_bit(b); step(1'b1, b, 1'b0); end
    chk("ar_locked", 32'(locked), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_drop", 32'(locked), 32'd0);
    chk("ar_hist", 32'(hist), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Randomized stream: strobe gaps, bit errors, zero bursts, occasional clear
    gen_reset();
    mm_before = mm_total;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        step(1'b0, 1'b0, 1'b1);
        gen_reset();
      end else if ($urandom_range(0, 3) == 0) begin
        step(1'b0, 1'(($urandom)), 1'b0);
      end else if ($urandom_range(0, 299) == 0) begin
        repeat (9) step(1'b1, 1'b0, 1'b0);
      end else begin
        gen_bit(b);
        if ($urandom_range(0, 39) == 0) b = ~b;
        step(1'b1, b, 1'b0);
      end
    end
    chk("rand_saw_mm", 32'(mm_total > mm_before), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
